// File: rtl/coffee_selector.sv
// Front-panel input side of the coffee machine: synchronizes and debounces the buttons,
// holds the one-hot drink choice and runs the REQ/BUSY handshake with the brewer.
module coffee_selector #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int TIMEOUT_CYCLES  = 250000000,
  parameter int CNT_W           = 28
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] BTN,
  input  logic       BTN_OK,
  input  logic       BTN_CANCEL,
  input  logic       BUSY,
  output logic       S0,
  output logic       S1,
  output logic       S2,
  output logic       S3,
  output logic [1:0] SEL_CODE,
  output logic       VALID,
  output logic       REQ
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SELECTED, CONFIRM, BREWING} state_t;

  // Bits 0..3 are the drink buttons, bit 4 is OK, bit 5 is CANCEL.
  logic [5:0] raw;
  logic [5:0] press;

  assign raw = {BTN_CANCEL, BTN_OK, BTN};

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_btn
      logic             sync1_q;
      logic             sync2_q;
      logic             level_q;
      logic             press_q;
      logic [CNT_W-1:0] cnt_q;

      // Released level after reset, so a button held through reset debounces into one press.
      always_ff @(posedge CLK) begin
        if (!RST_N) begin
          sync1_q <= 1'b1;
          sync2_q <= 1'b1;
          level_q <= 1'b1;
          press_q <= 1'b0;
          cnt_q   <= '0;
        end else begin
          sync1_q <= raw[gi];
          sync2_q <= sync1_q;
          press_q <= 1'b0;
          if (sync2_q == level_q) begin
            cnt_q <= '0;
          end else if (cnt_q == DB_LAST) begin
            cnt_q   <= '0;
            level_q <= sync2_q;
            press_q <= ~sync2_q;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
      end

      assign press[gi] = press_q;
    end
  endgenerate

  logic       drink_hit;
  logic [3:0] drink_oh_d;

  // Isolate the lowest-index drink press; simultaneous higher-index presses are dropped.
  assign drink_hit  = |press[3:0];
  assign drink_oh_d = press[3:0] & (~press[3:0] + 4'd1);

  state_t           state_q;
  logic [3:0]       sel_q;
  logic             req_q;
  logic [CNT_W-1:0] tmo_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      sel_q   <= '0;
      req_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          tmo_q <= '0;
          if (drink_hit) begin
            state_q <= SELECTED;
            sel_q   <= drink_oh_d;
          end
        end
        SELECTED: begin
          if (press[5]) begin
            state_q <= IDLE;
            sel_q   <= '0;
            tmo_q   <= '0;
          end else if (press[4]) begin
            state_q <= CONFIRM;
            req_q   <= 1'b1;
            tmo_q   <= '0;
          end else if (drink_hit) begin
            sel_q <= drink_oh_d;
            tmo_q <= '0;
          end else if (tmo_q == TMO_LAST) begin
            state_q <= IDLE;
            sel_q   <= '0;
            tmo_q   <= '0;
          end else begin
            tmo_q <= tmo_q + CNT_W'(1);
          end
        end
        CONFIRM: begin
          // An acknowledge beats a cancel arriving in the same cycle.
          if (BUSY) begin
            state_q <= BREWING;
            req_q   <= 1'b0;
          end else if (press[5]) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            sel_q   <= '0;
          end
        end
        BREWING: begin
          if (!BUSY) begin
            state_q <= IDLE;
            sel_q   <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          sel_q   <= '0;
          req_q   <= 1'b0;
          tmo_q   <= '0;
        end
      endcase
    end
  end

  assign {S3, S2, S1, S0} = sel_q;
  assign REQ              = req_q;
  assign VALID            = $onehot(sel_q);

  always_comb begin
    SEL_CODE = 2'd0;
    case (sel_q)
      4'b0010: SEL_CODE = 2'd1;
      4'b0100: SEL_CODE = 2'd2;
      4'b1000: SEL_CODE = 2'd3;
      default: SEL_CODE = 2'd0;
    endcase
  end

endmodule

// File: doc/coffee_selector.md
Name: coffee_selector

Overview:
- Input-side counterpart of the multiplexed 7-segment status display.
- Synchronizes and debounces the raw front-panel push-buttons: four drink buttons, OK and CANCEL.
- Holds the user's drink choice as the one-hot S0..S3 levels that the display decoders consume.
- Runs a req/ack handshake with the brewing controller (REQ/BUSY) and returns to idle when brewing completes.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive stable samples required to accept a level change (1 ms at 50 MHz).
- TIMEOUT_CYCLES, 250000000: cycles without a press in SELECTED before the choice is dropped (5 s).
- CNT_W, 28: counter width; must satisfy 2^CNT_W > max(DEBOUNCE_CYCLES, TIMEOUT_CYCLES).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  synchronous active-low reset.
- BTN  in  4  raw drink buttons, active-low (0 = pressed); BTN[i] selects drink i.
- BTN_OK  in  1  raw confirm button, active-low.
- BTN_CANCEL  in  1  raw cancel button, active-low.
- BUSY  in  1  brewing controller acknowledge/busy, active-high, synchronous to CLK.
- S0, S1, S2, S3  out  1 each  one-hot selected drink, to display decoders.
- SEL_CODE  out  2  binary index of held selection; 0 when none held.
- VALID  out  1  high when exactly one S output is high.
- REQ  out  1  brew request level, held until acknowledged by BUSY.

Behaviour:
- Reset (RST_N=0 at a CLK edge):
  - State = IDLE; S0..S3, SEL_CODE, VALID and REQ = 0.
  - Synchronizer flops, candidate levels and debounced levels = 1 (released); all counters = 0.
- Synchronizer: two flops per raw input (6 inputs).
- Debouncer, one per input:
  - Counter increments while the synchronized sample differs from the debounced level; clears to 0 on any agreeing sample.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A 1→0 flip produces a one-cycle press event; a 0→1 flip produces no event.
  - A button held through reset registers as one press.
- Latency: a raw press held stable updates S on the edge DEBOUNCE_CYCLES+3 after the first edge that samples it low.
- Event priority in the same cycle: CANCEL > OK > drink buttons; among drink buttons the lowest index wins and the others are discarded.
- FSM states:
  - IDLE:
    - Drink press i → SELECTED, S=onehot(i).
    - OK and CANCEL ignored.
  - SELECTED:
    - Drink press j → reselect j (j=i allowed) and clear the timeout counter.
    - CANCEL → IDLE, S cleared.
    - OK → CONFIRM.
    - Timeout counter increments each cycle; reaching TIMEOUT_CYCLES → IDLE, S cleared.
  - CONFIRM:
    - REQ=1 and S held.
    - BUSY=1 → BREWING, with REQ dropping on the same edge.
    - CANCEL (BUSY still 0) → IDLE, REQ=0, S cleared.
    - Drink and OK presses ignored.
  - BREWING:
    - REQ=0, S held.
    - BUSY=0 → IDLE, S cleared.
    - All presses ignored, including CANCEL.
- Simultaneous events:
  - BUSY=1 and a CANCEL event in the same CONFIRM cycle: BUSY wins → BREWING.
  - BUSY already high on entry to CONFIRM: REQ is high for exactly one cycle.
- Outputs are registered and change only on CLK edges. SEL_CODE and VALID are derived from the same registered one-hot state.
- RST_N low in any state returns to IDLE on that edge; no REQ glitch.

Test Plan (bench overrides DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20):
- Select: BTN[2] low for 10 cycles, bouncing 0/1 every cycle for the first 3 → exactly one event; S2=1, SEL_CODE=2, VALID=1 at edge 7 after the first stable-low sample; other S outputs 0.
- Priority and reselect: BTN[1] and BTN[3] pressed together → S1 only. Later BTN[3] alone → S3, SEL_CODE=3.
- Handshake: select drink 0, press OK → REQ=1. BUSY raised 5 cycles later → REQ=0 on that edge, state BREWING, S0 held. BUSY lowered → S0..S3=0, VALID=0.
- Cancel paths:
  - CANCEL in SELECTED → IDLE.
  - CANCEL in CONFIRM with BUSY=0 → REQ=0, IDLE.
  - CANCEL in BREWING → ignored; S held until BUSY falls.
  - CANCEL and OK pressed together in SELECTED → IDLE.
- Timeout: select drink 1 with no further presses → S1 clears exactly 20 cycles after selection. A BTN[1] press at cycle 15 restarts the count.
- Reset mid-operation: RST_N=0 for 1 cycle in CONFIRM → REQ, S0..S3, SEL_CODE, VALID = 0 on that edge. BTN[0] held low through reset → S0=1 after 4+3 edges.
